// File: rtl/event_encoder_4x2.sv
// Four-source event encoder: captures request bits into a pending vector and
// presents them one at a time, by priority, over a valid/ready handshake.
module event_encoder_4x2 #(
   parameter bit HI_PRIO = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] req,
   input  logic       ready,
   output logic [1:0] code,
   output logic       valid,
   output logic [3:0] pending,
   output logic       overflow
);

   localparam logic ST_IDLE    = 1'b0;
   localparam logic ST_PRESENT = 1'b1;

   logic       r_state;
   logic [1:0] r_code;
   logic [3:0] r_pending;
   logic       r_overflow;

   logic       w_state_nxt;
   logic [1:0] w_code_nxt;
   logic [3:0] w_served;
   logic [3:0] w_pend_kept;
   logic [3:0] w_pend_nxt;
   logic       w_ovf_nxt;

   function automatic logic [1:0] f_select(input logic [3:0] v);
      logic [1:0] sel;
      sel = 2'd0;
      if (HI_PRIO) begin
         for (int i = 0; i < 4; i++)
            if (v[i]) sel = i[1:0];
      end else begin
         for (int i = 3; i >= 0; i--)
            if (v[i]) sel = i[1:0];
      end
      return sel;
   endfunction

   always_comb begin
      // NOTE: every signal gets a default first, so no path leaves it unassigned (no latch).
      w_served    = 4'b0000;
      if (r_state == ST_PRESENT && ready)
         w_served = 4'b0001 << r_code;
      w_pend_kept = r_pending & ~w_served;
      w_pend_nxt  = en ? (w_pend_kept | req) : w_pend_kept;
      w_ovf_nxt   = en & (|(req & w_pend_kept));

      w_state_nxt = r_state;
      w_code_nxt  = r_code;
      case (r_state)
         ST_IDLE: begin
            if (|r_pending) begin
               w_state_nxt = ST_PRESENT;
               w_code_nxt  = f_select(r_pending);
            end
         end
         default: begin
            // A same-edge re-request of the served bit keeps the presentation going.
            if (ready) begin
               if (|w_pend_nxt) w_code_nxt  = f_select(w_pend_nxt);
               else             w_state_nxt = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_code     <= 2'b00;
         r_pending  <= 4'b0000;
         r_overflow <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         r_state    <= w_state_nxt;
         r_code     <= w_code_nxt;
         r_pending  <= w_pend_nxt;
         r_overflow <= w_ovf_nxt;
      end
   end

   assign code     = r_code;
   assign valid    = r_state;
   assign pending  = r_pending;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_event_encoder_4x2.sv
// Directed bench for event_encoder_4x2; two instances cover both priority orders.
module tb_event_encoder_4x2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [3:0] req;
   logic       ready;
   logic [1:0] hi_code, lo_code;
   logic       hi_valid, lo_valid;
   logic [3:0] hi_pending, lo_pending;
   logic       hi_overflow, lo_overflow;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   event_encoder_4x2 #(.HI_PRIO(1'b1)) u_hi (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .ready(ready),
      .code(hi_code), .valid(hi_valid), .pending(hi_pending), .overflow(hi_overflow)
   );

   event_encoder_4x2 #(.HI_PRIO(1'b0)) u_lo (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .ready(ready),
      .code(lo_code), .valid(lo_valid), .pending(lo_pending), .overflow(lo_overflow)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge; inputs change and outputs are sampled 1ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; req = 4'b0000; ready = 1'b0;
      step(); step();
      check("rst_pending", 8'(hi_pending), 8'h0);
      check("rst_valid",   8'(hi_valid),   8'h0);
      check("rst_code",    8'(hi_code),    8'h0);
      rst_n = 1'b1;

      // Asynchronous reset in the middle of a presentation
      en = 1'b1; req = 4'b1111;
      step();
      check("pre_rst_pending", 8'(hi_pending), 8'hf);
      step();
      check("pre_rst_valid",   8'(hi_valid),    8'h1);
      check("pre_rst_code",    8'(hi_code),     8'h3);
      check("pre_rst_ovf",     8'(hi_overflow), 8'h1);
      #2 rst_n = 1'b0;
      #1;
      check("async_pending", 8'(hi_pending),  8'h0);
      check("async_valid",   8'(hi_valid),    8'h0);
      check("async_code",    8'(hi_code),     8'h0);
      check("async_ovf",     8'(hi_overflow), 8'h0);
      en = 1'b0; req = 4'b0000; rst_n = 1'b1;
      step();
      check("post_rst_pending", 8'(hi_pending), 8'h0);
      check("post_rst_valid",   8'(hi_valid),   8'h0);

      // Single event latency
      en = 1'b1; req = 4'b0100; ready = 1'b1;
      step();
      check("single_k_pending", 8'(hi_pending), 8'h4);
      check("single_k_valid",   8'(hi_valid),   8'h0);
      req = 4'b0000;
      step();
      check("single_k1_valid",   8'(hi_valid),   8'h1);
      check("single_k1_code",    8'(hi_code),    8'h2);
      check("single_k1_pending", 8'(hi_pending), 8'h4);
      step();
      check("single_k2_valid",   8'(hi_valid),   8'h0);
      check("single_k2_pending", 8'(hi_pending), 8'h0);

      // Priority drain, both orders at once
      req = 4'b1011;
      step();
      check("drain_pending", 8'(hi_pending), 8'hb);
      req = 4'b0000;
      step();
      check("drain_hi_c0", 8'(hi_code), 8'h3);
      check("drain_lo_c0", 8'(lo_code), 8'h0);
      check("drain_hi_v0", 8'(hi_valid), 8'h1);
      step();
      check("drain_hi_c1", 8'(hi_code), 8'h1);
      check("drain_lo_c1", 8'(lo_code), 8'h1);
      check("drain_hi_v1", 8'(hi_valid), 8'h1);
      step();
      check("drain_hi_c2", 8'(hi_code), 8'h0);
      check("drain_lo_c2", 8'(lo_code), 8'h3);
      check("drain_lo_v2", 8'(lo_valid), 8'h1);
      step();
      check("drain_hi_v3", 8'(hi_valid), 8'h0);
      check("drain_lo_v3", 8'(lo_valid), 8'h0);

      // Backpressure with a higher-priority late arrival
      ready = 1'b0; req = 4'b0001;
      step();
      req = 4'b1000;
      step();
      req = 4'b0000;
      for (int i = 0; i < 4; i++) step();
      check("bp_code",    8'(hi_code),     8'h0);
      check("bp_valid",   8'(hi_valid),    8'h1);
      check("bp_pending", 8'(hi_pending),  8'h9);
      check("bp_ovf",     8'(hi_overflow), 8'h0);
      ready = 1'b1;
      step();
      check("bp_next_code",  8'(hi_code),  8'h3);
      check("bp_next_valid", 8'(hi_valid), 8'h1);
      step();
      check("bp_done_valid", 8'(hi_valid), 8'h0);
      ready = 1'b0;

      // Overflow pulse, then same-edge re-request of the served bit
      req = 4'b0010;
      step();
      req = 4'b0000;
      step();
      check("ovf_pre_code", 8'(hi_code), 8'h1);
      req = 4'b0010;
      step();
      check("ovf_pulse",   8'(hi_overflow), 8'h1);
      check("ovf_pending", 8'(hi_pending),  8'h2);
      req = 4'b0000;
      step();
      check("ovf_one_cycle", 8'(hi_overflow), 8'h0);
      ready = 1'b1; req = 4'b0010;
      step();
      check("rereq_pending", 8'(hi_pending),  8'h2);
      check("rereq_ovf",     8'(hi_overflow), 8'h0);
      check("rereq_valid",   8'(hi_valid),    8'h1);
      check("rereq_code",    8'(hi_code),     8'h1);
      req = 4'b0000;
      step();
      check("rereq_done_valid",   8'(hi_valid),   8'h0);
      check("rereq_done_pending", 8'(hi_pending), 8'h0);
      ready = 1'b0;

      // Capture enable gating
      en = 1'b0; req = 4'b1111;
      for (int i = 0; i < 4; i++) step();
      check("gate_pending", 8'(hi_pending),  8'h0);
      check("gate_valid",   8'(hi_valid),    8'h0);
      check("gate_ovf",     8'(hi_overflow), 8'h0);
      en = 1'b1; req = 4'b0110;
      step();
      en = 1'b0; req = 4'b1111;
      step();
      check("gate_p_code",  8'(hi_code),     8'h2);
      check("gate_p_valid", 8'(hi_valid),    8'h1);
      check("gate_p_ovf",   8'(hi_overflow), 8'h0);
      ready = 1'b1;
      step();
      check("gate_p2_code",    8'(hi_code),     8'h1);
      check("gate_p2_pending", 8'(hi_pending),  8'h2);
      check("gate_p2_ovf",     8'(hi_overflow), 8'h0);
      step();
      check("gate_end_valid",   8'(hi_valid),   8'h0);
      check("gate_end_pending", 8'(hi_pending), 8'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/event_encoder_4x2.md
EVENT_ENCODER_4X2 -- requirements
Module: event_encoder_4x2

Interface
REQ-001 Parameter: HI_PRIO, default 1, meaning 1 = req[3] highest priority, 0 = req[0] highest priority.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  capture enable; 1 = req sampled, 0 = req ignored.
REQ-005 req  input  4  one bit per event source, sampled every enabled cycle; multiple bits may be high.
REQ-006 code  output  2  binary index of the event being presented; registered.
REQ-007 valid  output  1  code holds a pending event; registered.
REQ-008 ready  input  1  consumer accepts code when valid=1 and ready=1 at a rising edge.
REQ-009 pending  output  4  captured-but-unserved events, bit i = source i; registered.
REQ-010 overflow  output  1  one-cycle pulse: new request merged into an already-pending bit; registered.

Function
REQ-011 Capture: at each rising edge with en=1, pending <= (pending & ~served) | req; with en=0, pending <= pending & ~served.
REQ-012 served = one-hot of code when valid=1 and ready=1 at that edge, else 4'b0000.
REQ-013 Priority: the selected index is the highest-priority set bit of (pending & ~served) per HI_PRIO; never computed from an all-zero vector.
REQ-014 FSM states: IDLE (valid=0) and PRESENT (valid=1); no other states.
REQ-015 IDLE -> PRESENT at an edge where pending != 0; code loaded with the selected index of the registered pending vector.
REQ-016 IDLE stays IDLE while pending == 0; code retains its last value.
REQ-017 PRESENT with ready=0: code, valid held stable; new captures do not change code even if higher priority.
REQ-018 PRESENT with ready=1: served bit cleared; if (pending & ~served) != 0, stay PRESENT and load the next selected index (back-to-back, no bubble); else -> IDLE, valid=0.
REQ-019 Latency: req bit set at edge k (pending empty, IDLE) -> pending bit at edge k, valid=1 with code after edge k+1.
REQ-020 Same bit requested in the cycle it is served: bit remains set in pending (new event), overflow=0.
REQ-021 Request on a bit set in pending and not being served: merged, overflow=1 for exactly one cycle after that edge; otherwise overflow=0.
REQ-022 overflow evaluated only when en=1.
REQ-023 en=0 does not abort an in-flight presentation: valid/code held, handshake completes, remaining pending bits still served.
REQ-024 ready ignored while valid=0; no bit cleared.
REQ-025 Throughput: one event accepted per cycle maximum while ready=1 continuously.

Reset
REQ-026 rst_n=0 immediately (no clock needed) forces pending=4'b0000, valid=0, code=2'b00, overflow=0, FSM=IDLE.
REQ-027 Reset asserted mid-presentation discards all pending events and the presented code; no event survives reset.
REQ-028 First capture after rst_n deasserts occurs at the first rising edge with rst_n=1 and en=1.

Verification
REQ-029 Reset: drive req=4'b1111, en=1, pulse rst_n low between edges -> pending=0000, valid=0, code=00 asserted before next edge.
REQ-030 Single event: IDLE, en=1, req=4'b0100 for one cycle at edge k, ready=1 -> valid=1, code=10 after edge k+1; valid=0 after edge k+2; pending=0000.
REQ-031 Priority drain, HI_PRIO=1: req=4'b1011 one cycle, ready=1 -> codes 11,01,00 on consecutive cycles, then valid=0; repeat with HI_PRIO=0 -> 00,01,11.
REQ-032 Backpressure: req=4'b0001 then ready=0 for 5 cycles while req=4'b1000 arrives -> code stays 00, valid=1, pending=1001; ready=1 -> 00 accepted, then 11.
REQ-033 Overflow and same-cycle re-request: pending=0010 held (ready=0), req=0010 -> overflow pulses 1 cycle, pending=0010; then ready=1 with req=0010 same edge -> pending=0010, overflow=0, valid stays 1, code=01.
REQ-034 en gating: en=0, req=4'b1111 for 4 cycles -> pending=0000, valid=0; en=0 during PRESENT with pending=0110 -> both codes 10, 01 still delivered.
